acc_muldiv_seq: RTL and testbench

ACC_MULDIV_SEQ -- requirements
Module: acc_muldiv_seq

---
 rtl/acc_muldiv_seq.sv | 66 ++++++
 tb/tb_acc_muldiv_seq.sv | 118 +++++++++++
 2 files changed

// File: rtl/acc_muldiv_seq.sv
// acc_muldiv_seq: accumulator sequencer driving an external 4-bit ALU for load, add, shift-add multiply and restoring divide
module acc_muldiv_seq (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [1:0] op_code,
  input  logic [3:0] operand_a,
  input  logic [3:0] alu_data,
  input  logic       cout,
  output logic [3:0] acc_high_data,
  output logic       alu_lsb,
  output logic       op_add,
  output logic       op_mul,
  output logic       op_div,
  output logic [7:0] acc_data,
  output logic       busy,
  output logic       done
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [1:0] cnt_q, cnt_d;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q   <= 8'h00;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        acc_d   = op_code == 2'b01 ? {alu_data, acc_q[3:0]} : {4'h0, operand_a};
        cnt_d   = 2'd0;
        state_d = op_code == 2'b10 ? MUL : op_code == 2'b11 ? DIV : DONE;
      end
      MUL: begin
        acc_d   = acc_q[0] ? {cout, alu_data, acc_q[3:1]} : {1'b0, acc_q[7:1]};
        cnt_d   = cnt_q + 2'd1;
        state_d = cnt_q == 2'd3 ? DONE : MUL;
      end
      DIV: begin
        // acc[7] set means the shifted partial remainder already exceeds 4 bits, so subtract regardless of borrow
        acc_d   = (cout | acc_q[7]) ? {alu_data, acc_q[2:0], 1'b1} : {acc_q[6:0], 1'b0};
        cnt_d   = cnt_q + 2'd1;
        state_d = cnt_q == 2'd3 ? DONE : DIV;
      end
      default: state_d = IDLE;
    endcase
  end
  assign op_add        = state_q == IDLE && start && op_code == 2'b01;
  assign op_mul        = state_q == MUL;
  assign op_div        = state_q == DIV;
  assign acc_high_data = op_div ? acc_q[6:3] : acc_q[7:4];
  assign alu_lsb       = op_mul & acc_q[0];
  assign acc_data      = acc_q;
  assign busy          = op_mul | op_div;
  assign done          = state_q == DONE;
endmodule

// File: tb/tb_acc_muldiv_seq.sv
// tb_acc_muldiv_seq: randomized bench with an arithmetic reference model and a behavioural external ALU
module tb_acc_muldiv_seq;
  logic       clk = 0, reset_n = 0, start = 0, cout;
  logic [1:0] op_code = 0;
  logic [3:0] operand_a = 0, alu_data, acc_high_data, b_val = 0;
  logic       alu_lsb, op_add, op_mul, op_div, busy, done;
  logic [7:0] acc_data, acc_ref = 0;
  logic [4:0] sum, diff;
  int total = 0, bad = 0;
  acc_muldiv_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op_code(op_code),
    .operand_a(operand_a), .alu_data(alu_data), .cout(cout),
    .acc_high_data(acc_high_data), .alu_lsb(alu_lsb), .op_add(op_add),
    .op_mul(op_mul), .op_div(op_div), .acc_data(acc_data), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always_comb begin
    sum      = {1'b0, acc_high_data} + {1'b0, b_val};
    diff     = {1'b0, acc_high_data} - {1'b0, b_val};
    alu_data = op_div ? diff[3:0] : sum[3:0];
    cout     = op_div ? ~diff[4] : sum[4];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic run(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [7:0] exp;
    logic [4:0] add_sum;
    int lat, ops, bsy, odd;
    bit seen_c, got_done;
    add_sum = {1'b0, acc_ref[7:4]} + {1'b0, b};
    exp = op == 2'b00 ? {4'h0, a} :
          op == 2'b01 ? {add_sum[3:0], acc_ref[3:0]} :
          op == 2'b10 ? 8'(a * b) :
          b == 0 ? {a, 4'hF} : {4'(a % b), 4'(a / b)};
    @(negedge clk);
    start = 1; op_code = op; operand_a = a; b_val = b;
    #1;
    ops = int'(op_add | op_mul | op_div);
    seen_c = op_add & cout;
    odd = int'($countones({op_add, op_mul, op_div}) > 1) + int'(alu_lsb);
    lat = 0; bsy = 0; got_done = 0;
    while (lat < 12 && !got_done) begin
      @(posedge clk);
      lat++;
      #1;
      start = 1'($urandom); op_code = 2'($urandom); operand_a = 4'($urandom);
      #1;
      if ($countones({op_add, op_mul, op_div}) > 1 || (alu_lsb && !op_mul)) odd++;
      if (done) got_done = 1;
      else begin
        if (busy) bsy++;
        if (op_add | op_mul | op_div) ops++;
      end
    end
    start = 0;
    check($sformatf("acc op%0d a=%0h b=%0h", op, a, b), acc_data, exp);
    check($sformatf("latency op%0d", op), lat, op[1] ? 5 : 1);
    check($sformatf("strobes op%0d", op), ops, op == 2'b00 ? 0 : op == 2'b01 ? 1 : 4);
    check($sformatf("busy op%0d", op), bsy, op[1] ? 4 : 0);
    check($sformatf("exclusive op%0d", op), odd, 0);
    if (op == 2'b01) check("add cout", seen_c, add_sum[4]);
    @(posedge clk);
    #1;
    check("done one cycle", done, 0);
    acc_ref = exp;
  endtask
  initial begin
    int nd;
    #1;
    check("rst acc", acc_data, 8'h00);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst strobes", {op_add, op_mul, op_div}, 3'b000);
    check("rst high", acc_high_data, 4'h0);
    repeat (2) @(negedge clk);
    reset_n = 1;
    run(2'b00, 4'h9, 4'h0);
    check("load 9", acc_data, 8'h09);
    run(2'b10, 4'hF, 4'hF);
    check("mul ff", acc_data, 8'hE1);
    run(2'b01, 4'h0, 4'h3);
    check("add 3", acc_data, 8'h11);
    run(2'b11, 4'hD, 4'h3);
    check("div d/3", acc_data, 8'h14);
    run(2'b11, 4'h6, 4'h0);
    check("div by 0", acc_data, 8'h6F);
    for (int i = 0; i < 40; i++) run(2'($urandom), 4'($urandom), 4'($urandom));
    @(negedge clk);
    start = 1; op_code = 2'b10; operand_a = 4'hF; b_val = 4'hF;
    @(posedge clk);
    #1 start = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 0;
    #1;
    check("abort acc", acc_data, 8'h00);
    check("abort busy", busy, 0);
    check("abort high", acc_high_data, 4'h0);
    nd = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) nd++;
    end
    reset_n = 1;
    @(negedge clk);
    if (done) nd++;
    check("abort no done", nd, 0);
    acc_ref = 0;
    run(2'b00, 4'h5, 4'h0);
    check("load after abort", acc_data, 8'h05);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
